sc_stream_engine: RTL and testbench

Parametrised stream-cipher engine for the UART lab path. It takes the UART receive byte stream and implements three modes:
- key load;
- encrypt, where printable ASCII becomes two ASCII-hex characters;
- decrypt, where ASCII-hex pairs become a printable character.

It generalises the 32-bit/8-nibble cipher to a configurable key/LFSR width and tap polynomial. It adds a real ready/valid transmit handshake with backpressure, overrun detection and zero-key protection. It sits between the UART receiver and the transmit buffer.

---
 rtl/sc_stream_engine.sv | 187 ++++++++++++++++++
 tb/tb_sc_stream_engine.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sc_stream_engine.sv
// Stream-cipher engine between the UART receiver and the transmit buffer.
// Loads a hex key, encrypts printable bytes to hex pairs, decrypts hex pairs.
module sc_stream_engine #(
    parameter int          KEY_NIB = 8,
    parameter logic [63:0] TAPS    = 64'h0000_0000_0040_0007
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       print_buf,
    output logic       err,
    output logic [2:0] mode
);
    localparam int W = 4 * KEY_NIB;
    localparam logic [W-1:0] TapMask = TAPS[W-1:0];
    localparam logic [W-1:0] One = {{(W - 1){1'b0}}, 1'b1};
    localparam logic [4:0] NibLast = 5'(KEY_NIB - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, LOAD_CR, ENC, ENC_LS, DEC_HI, DEC_LO, DEC_OUT
    } state_t;

    state_t state, stateNext;
    logic [W-1:0] keyQ, keyNext, lfsrQ, lfsrNext, lfsrStep;
    logic [4:0] cntQ, cntNext;
    logic [7:0] byteQ, byteNext, cipher, decByte, txDataNext;
    logic [3:0] hiQ, hiNext, nib;
    logic txValidNext, printNext, errNext;
    logic [2:0] modeNext;
    logic accept, handshake, isHex, isCr, isPrint;

    function automatic logic [7:0] hexChar(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    function automatic logic printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    assign accept    = rx_valid && !tx_valid;
    assign handshake = tx_valid && tx_ready;
    assign isCr      = rx_data == 8'h0D;
    assign isPrint   = printable(rx_data);
    assign lfsrStep  = {lfsrQ[W-2:0], 1'b0} ^ (lfsrQ[W-1] ? TapMask : '0);
    assign cipher    = rx_data ^ lfsrQ[7:0];
    assign decByte   = {hiQ, nib} ^ lfsrQ[7:0];

    always_comb begin
        isHex = 1'b0;
        nib   = 4'h0;
        unique case (1'b1)
            (rx_data >= 8'h30 && rx_data <= 8'h39): begin
                isHex = 1'b1;
                nib   = rx_data[3:0];
            end
            (rx_data >= 8'h41 && rx_data <= 8'h46),
            (rx_data >= 8'h61 && rx_data <= 8'h66): begin
                isHex = 1'b1;
                nib   = rx_data[3:0] + 4'd9;
            end
            default: ;
        endcase
    end

    always_comb begin
        stateNext   = state;
        keyNext     = keyQ;
        lfsrNext    = lfsrQ;
        cntNext     = cntQ;
        byteNext    = byteQ;
        hiNext      = hiQ;
        txValidNext = tx_valid;
        txDataNext  = tx_data;
        printNext   = accept && isCr;
        errNext     = rx_valid && tx_valid;
        unique case (state)
            IDLE: if (accept) begin
                if (rx_data == 8'h45) stateNext = ENC;
                else if (rx_data == 8'h44) stateNext = DEC_HI;
                else if (rx_data == 8'h4C) begin
                    stateNext = LOAD;
                    cntNext   = 5'd0;
                end
            end
            LOAD: if (accept) begin
                if (isHex) begin
                    keyNext = {keyQ[W-5:0], nib};
                    cntNext = cntQ + 5'd1;
                    if (cntQ == NibLast) stateNext = LOAD_CR;
                end else if (isCr) begin
                    stateNext = IDLE;
                    errNext   = 1'b1;
                end
            end
            LOAD_CR: if (accept && isCr) begin
                // an all-zero LFSR would lock up, so substitute 1
                lfsrNext  = (keyQ == '0) ? One : keyQ;
                stateNext = IDLE;
            end
            ENC: begin
                if (handshake) begin
                    stateNext  = ENC_LS;
                    txDataNext = hexChar(byteQ[3:0]);
                end else if (accept) begin
                    if (isPrint) begin
                        byteNext    = cipher;
                        lfsrNext    = lfsrStep;
                        txValidNext = 1'b1;
                        txDataNext  = hexChar(cipher[7:4]);
                    end else if (isCr) begin
                        stateNext = IDLE;
                    end
                end
            end
            ENC_LS: if (handshake) begin
                txValidNext = 1'b0;
                stateNext   = ENC;
            end
            DEC_HI: if (accept) begin
                if (isHex) begin
                    hiNext    = nib;
                    stateNext = DEC_LO;
                end else if (isCr) begin
                    stateNext = IDLE;
                end
            end
            DEC_LO: if (accept) begin
                if (isHex) begin
                    byteNext    = decByte;
                    lfsrNext    = lfsrStep;
                    txValidNext = 1'b1;
                    txDataNext  = printable(decByte) ? decByte : 8'h2E;
                    stateNext   = DEC_OUT;
                end else if (isCr) begin
                    stateNext = IDLE;
                end
            end
            DEC_OUT: if (handshake) begin
                txValidNext = 1'b0;
                stateNext   = DEC_HI;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        modeNext = 3'b000;
        unique case (stateNext)
            LOAD, LOAD_CR:           modeNext = 3'b100;
            DEC_HI, DEC_LO, DEC_OUT: modeNext = 3'b010;
            ENC, ENC_LS:             modeNext = 3'b001;
            default:                 modeNext = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            keyQ      <= One;
            lfsrQ     <= One;
            cntQ      <= 5'd0;
            byteQ     <= 8'h00;
            hiQ       <= 4'h0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            print_buf <= 1'b0;
            err       <= 1'b0;
            mode      <= 3'b000;
        end else begin
            state     <= stateNext;
            keyQ      <= keyNext;
            lfsrQ     <= lfsrNext;
            cntQ      <= cntNext;
            byteQ     <= byteNext;
            hiQ       <= hiNext;
            tx_valid  <= txValidNext;
            tx_data   <= txDataNext;
            print_buf <= printNext;
            err       <= errNext;
            mode      <= modeNext;
        end
    end
endmodule

// File: tb/tb_sc_stream_engine.sv
// Directed bench for sc_stream_engine: 32-bit default instance and a
// 16-bit KEY_NIB=4 instance, sharing clock, reset and tx_ready.
module tb_sc_stream_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic rxValid = 1'b0;
    logic [7:0] rxData = 8'h00;
    logic txReady = 1'b1;

    logic txValidA, txValidB, printBufA, printBufB, errA, errB;
    logic [7:0] txDataA, txDataB;
    logic [2:0] modeA, modeB;

    logic txValid, printBuf, errOut;
    logic [7:0] txData;
    logic [2:0] mode;

    int nChecks = 0;
    int nErrors = 0;
    int pbCnt = 0;
    int erCnt = 0;
    int pb0, e0;
    logic [7:0] txQ[$];

    localparam logic [7:0] CR = 8'h0D;

    always #5 clk = ~clk;

    sc_stream_engine dutA (
        .clk(clk), .rst(rst),
        .rx_valid(rxValid && !sel), .rx_data(rxData),
        .tx_ready(txReady), .tx_valid(txValidA), .tx_data(txDataA),
        .print_buf(printBufA), .err(errA), .mode(modeA)
    );

    sc_stream_engine #(.KEY_NIB(4), .TAPS(64'h002D)) dutB (
        .clk(clk), .rst(rst),
        .rx_valid(rxValid && sel), .rx_data(rxData),
        .tx_ready(txReady), .tx_valid(txValidB), .tx_data(txDataB),
        .print_buf(printBufB), .err(errB), .mode(modeB)
    );

    assign txValid  = sel ? txValidB : txValidA;
    assign txData   = sel ? txDataB : txDataA;
    assign printBuf = sel ? printBufB : printBufA;
    assign errOut   = sel ? errB : errA;
    assign mode     = sel ? modeB : modeA;

    always @(negedge clk) begin
        if (!rst) begin
            if (txValid && txReady) txQ.push_back(txData);
            if (printBuf) pbCnt++;
            if (errOut) erCnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        int n = 0;
        while (txValid && n < 200) begin
            idle(1);
            n++;
        end
        if (n >= 200) check("txStuck", txValid, 0);
        rxValid = 1'b1;
        rxData  = b;
        idle(1);
        rxValid = 1'b0;
    endtask

    task automatic sendStr(input string s);
        for (int i = 0; i < s.len(); i++) sendByte(s[i]);
    endtask

    task automatic sendLine(input string s);
        sendStr(s);
        sendByte(CR);
    endtask

    task automatic expectTx(input string tag, input string s);
        int n = 0;
        while ((txValid || txQ.size() < s.len()) && n < 100) begin
            idle(1);
            n++;
        end
        check({tag, "Len"}, txQ.size(), s.len());
        for (int i = 0; i < s.len(); i++)
            if (i < txQ.size()) check(tag, txQ[i], s[i]);
        txQ.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle(3);
        rst = 1'b0;
        check("rstTxValid", txValid, 0);
        check("rstTxData", txData, 0);
        check("rstMode", mode, 0);
        check("rstPrint", printBuf, 0);
        check("rstErr", errOut, 0);
        check("rstModeB", modeB, 0);

        sendStr("L0000000");
        check("modeLoad", mode, 3'b100);
        sendByte("1");
        check("modeLoadCr", mode, 3'b100);
        pb0 = pbCnt;
        sendByte(CR);
        idle(1);
        check("modeIdle", mode, 0);
        check("pbLoad", pbCnt, pb0 + 1);
        sendByte("E");
        check("modeEnc", mode, 3'b001);
        sendStr("AA");
        expectTx("enc", "4043");
        pb0 = pbCnt;
        sendByte(CR);
        idle(1);
        check("pbEnc", pbCnt, pb0 + 1);
        check("modeEncEnd", mode, 0);

        sendLine("L00000001");
        sendByte("D");
        check("modeDec", mode, 3'b010);
        sendStr("40434a");
        expectTx("dec", "AAN");
        sendByte(CR);
        sendLine("L00000001");
        sendStr("D00");
        expectTx("decDot", ".");
        sendByte(CR);

        sendLine("L00000000");
        sendStr("EA");
        expectTx("zeroKey", "40");
        sendByte(CR);

        sendLine("L80000000");
        sendStr("EAA");
        expectTx("taps", "4146");
        sendByte(CR);

        sendLine("L12345678");
        e0 = erCnt;
        sendLine("L12");
        idle(1);
        check("abortErr", erCnt, e0 + 1);
        check("abortMode", mode, 0);
        sendStr("EAA");
        expectTx("abort", "39B1");
        sendByte(CR);

        sendLine("L00000001");
        sendByte("E");
        txReady = 1'b0;
        sendByte("A");
        check("bpMs", txData, "4");
        e0 = erCnt;
        rxValid = 1'b1;
        rxData  = "B";
        idle(1);
        rxValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("bpHold", txData, "4");
        end
        check("bpErr", erCnt, e0 + 1);
        check("bpValid", txValid, 1);
        txReady = 1'b1;
        expectTx("bp", "40");
        sendByte("A");
        expectTx("bpNext", "43");
        sendByte(CR);

        sel = 1'b1;
        idle(1);
        sendLine("L0001");
        sendStr("EA");
        expectTx("w16", "40");
        sendByte(CR);
        sendLine("L8000");
        sendStr("EAA");
        expectTx("w16Taps", "416C");
        txReady = 1'b0;
        sendByte("A");
        check("rsMs", txData, "1");
        txReady = 1'b1;
        idle(1);
        txReady = 1'b0;
        check("rsLs", txData, "B");
        check("rsMode", mode, 3'b001);
        rst = 1'b1;
        idle(1);
        check("rsRstMode", mode, 0);
        check("rsRstValid", txValid, 0);
        check("rsRstData", txData, 0);
        rst = 1'b0;
        txQ.delete();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
